// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the immediate generator: extension-mode encodings and default datapath width.
// Modes 6 and 7 are deliberately unassigned and decode as illegal.
package imm_gen_pipe_pkg;

    localparam int IMM_MODE_W            = 3;
    localparam int IMM_WORD_SIZE_DEFAULT = 16;

    typedef enum logic [IMM_MODE_W-1:0] {
        IMM_MODE_SEXT_IMM = 3'd0,
        IMM_MODE_ZEXT_IMM = 3'd1,
        IMM_MODE_LHI      = 3'd2,
        IMM_MODE_JMP_TGT  = 3'd3,
        IMM_MODE_SEXT_TGT = 3'd4,
        IMM_MODE_BR_TGT   = 3'd5
    } imm_mode_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational mode decode and immediate/target extension, zero latency.
// No state and no handshake; undefined modes yield value 0 with o_illegal set.
module imm_extend_core
    import imm_gen_pipe_pkg::*;
#(
    parameter int WORD_SIZE    = IMM_WORD_SIZE_DEFAULT,
    parameter int IMM_WIDTH    = 8,
    parameter int TARGET_WIDTH = 12
) (
    input  logic [IMM_MODE_W-1:0]   i_mode,
    input  logic [IMM_WIDTH-1:0]    i_imm,
    input  logic [TARGET_WIDTH-1:0] i_target,
    input  logic [WORD_SIZE-1:0]    i_pc,
    output logic [WORD_SIZE-1:0]    o_value,
    output logic                    o_illegal
);

    logic [WORD_SIZE-1:0] w_sext_imm;
    logic [WORD_SIZE-1:0] w_zext_imm;
    logic [WORD_SIZE-1:0] w_sext_tgt;

    assign w_sext_imm = {{(WORD_SIZE-IMM_WIDTH){i_imm[IMM_WIDTH-1]}}, i_imm};
    assign w_zext_imm = {{(WORD_SIZE-IMM_WIDTH){1'b0}}, i_imm};
    assign w_sext_tgt = {{(WORD_SIZE-TARGET_WIDTH){i_target[TARGET_WIDTH-1]}}, i_target};

    always_comb begin
        o_value   = '0;
        o_illegal = 1'b0;
        case (i_mode)
            IMM_MODE_SEXT_IMM: o_value = w_sext_imm;
            IMM_MODE_ZEXT_IMM: o_value = w_zext_imm;
            // Shift rather than concatenate so oversized immediates truncate cleanly.
            IMM_MODE_LHI:      o_value = w_zext_imm << (WORD_SIZE-IMM_WIDTH);
            IMM_MODE_JMP_TGT:  o_value = {i_pc[WORD_SIZE-1:TARGET_WIDTH], i_target};
            IMM_MODE_SEXT_TGT: o_value = w_sext_tgt;
            IMM_MODE_BR_TGT:   o_value = i_pc + WORD_SIZE'(1) + w_sext_imm;
            default:           o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: 1 cycle accept-to-out_valid, output register plus one-entry skid buffer.
// in_ready is registered (!skid valid) so decode streams at full rate with no out_ready->in_ready path.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int WORD_SIZE    = IMM_WORD_SIZE_DEFAULT,
    parameter int IMM_WIDTH    = 8,
    parameter int TARGET_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IMM_MODE_W-1:0]   in_mode,
    input  logic [IMM_WIDTH-1:0]    in_imm,
    input  logic [TARGET_WIDTH-1:0] in_target,
    input  logic [WORD_SIZE-1:0]    in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_SIZE-1:0]    out_value,
    output logic                    out_illegal
);

    logic [WORD_SIZE-1:0] w_value;
    logic                 w_illegal;
    logic                 w_accept;
    logic                 w_o_free;

    logic                 r_o_vld;
    logic [WORD_SIZE-1:0] r_o_value;
    logic                 r_o_illegal;
    logic                 r_s_vld;
    logic [WORD_SIZE-1:0] r_s_value;
    logic                 r_s_illegal;

    imm_extend_core #(
        .WORD_SIZE    (WORD_SIZE),
        .IMM_WIDTH    (IMM_WIDTH),
        .TARGET_WIDTH (TARGET_WIDTH)
    ) u_core (
        .i_mode    (in_mode),
        .i_imm     (in_imm),
        .i_target  (in_target),
        .i_pc      (in_pc),
        .o_value   (w_value),
        .o_illegal (w_illegal)
    );

    assign w_accept = in_valid && !r_s_vld && !flush;
    assign w_o_free = !r_o_vld || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_o_vld     <= 1'b0;
            r_o_value   <= '0;
            r_o_illegal <= 1'b0;
            r_s_vld     <= 1'b0;
            r_s_value   <= '0;
            r_s_illegal <= 1'b0;
        end else if (flush) begin
            r_o_vld <= 1'b0;
            r_s_vld <= 1'b0;
        end else if (w_o_free) begin
            // A full skid blocks in_ready, so draining it never coincides with an accept.
            if (r_s_vld) begin
                r_o_vld     <= 1'b1;
                r_o_value   <= r_s_value;
                r_o_illegal <= r_s_illegal;
                r_s_vld     <= 1'b0;
            end else begin
                r_o_vld <= w_accept;
                if (w_accept) begin
                    r_o_value   <= w_value;
                    r_o_illegal <= w_illegal;
                end
            end
        end else if (w_accept) begin
            r_s_vld     <= 1'b1;
            r_s_value   <= w_value;
            r_s_illegal <= w_illegal;
        end
    end

    assign in_ready    = !r_s_vld;
    assign out_valid   = r_o_vld;
    assign out_value   = r_o_value;
    assign out_illegal = r_o_illegal;

endmodule
